dram_fifo: RTL and testbench
============================

# dram_fifo

Parametrised synchronous FIFO built on distributed (LUT) RAM with one asynchronous read port, generalising the 16x1 dual-port distributed RAM primitive to WIDTH x 2^ADDR_BITS with pointer, occupancy and error logic. Used as a small buffer between producers and consumers in the same clock domain, such as UART receive/transmit, PS/2 and SPI byte streams feeding the RISC5 I/O space. First-word fall-through: the head word is always present on `rd_data` while `empty` is low.

## Interface

- `WIDTH`, 8: data word width in bits, 1..32.
- `ADDR_BITS`, 4: log2 of depth; depth `D = 2^ADDR_BITS`, ADDR_BITS 1..6.
- `AFULL_LEVEL`, 12: `afull` asserts when count >= AFULL_LEVEL; 1..D.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: push request.
- `wr_data` in WIDTH: word to push.
- `rd_en` in 1: pop request; acknowledges the current head word.
- `rd_data` out WIDTH: head word, combinational from RAM at the read pointer.
- `empty` out 1: no words stored.
- `full` out 1: D words stored.
- `afull` out 1: count >= AFULL_LEVEL.
- `count` out ADDR_BITS+1: words stored, 0..D.
- `ovf` out 1: sticky, push attempted while full.
- `udf` out 1: sticky, pop attempted while empty.
- `clr_err` in 1: synchronous clear of `ovf` and `udf`.

## Operation

- Storage is D x WIDTH distributed RAM with synchronous write at `wr_ptr` and asynchronous read at `rd_ptr`. RAM contents are not cleared by reset. Simulation initial contents are all zero.
- State consists of `wr_ptr` and `rd_ptr` (each ADDR_BITS wide, wrapping modulo D), `count` (ADDR_BITS+1 wide), `ovf` and `udf`.
- Push is accepted iff `wr_en && !full`: `mem[wr_ptr] <= wr_data`, then `wr_ptr` increments.
- Pop is accepted iff `rd_en && !empty`: `rd_ptr` increments.
- Count update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- Flags are decoded from `count`:
  - `empty = (count == 0)`
  - `full = (count == D)`
  - `afull = (count >= AFULL_LEVEL)`
- Simultaneous push and pop:
  - When empty: only the push is accepted. `udf` sets if `rd_en` is high. Count becomes 1.
  - When full: only the pop is accepted. `ovf` sets if `wr_en` is high. Count becomes D-1.
  - Otherwise: both are accepted and count is unchanged.
- A rejected push leaves RAM and `wr_ptr` untouched. A rejected pop leaves `rd_ptr` untouched.
- Sticky flags:
  - `ovf` sets on `wr_en && full`; `udf` sets on `rd_en && empty`.
  - `clr_err` clears both flags, but set wins over clear in the same cycle.
- `rd_data` is undefined while `empty` is high. It shows stale RAM contents and must not be checked.
- Pointer wrap: `wr_ptr` and `rd_ptr` go from D-1 to 0 with no other effect.

## Timing

- Reset (`rst_n` low, asynchronous): `wr_ptr=0`, `rd_ptr=0`, `count=0`, `empty=1`, `full=0`, `afull=0`, `ovf=0`, `udf=0`. `rd_data` is don't-care.
- Reset asserted mid-operation discards all stored words immediately, without waiting for `clk`. Push or pop requests in the cycle of deassertion are ignored only if `rst_n` is still low at the edge.
- Push latency: a word pushed at edge N into an empty FIFO gives `empty=0` and `rd_data=word` after edge N. It is readable in cycle N+1.
- Pop: `rd_data` changes to the next word combinationally after the popping edge. Throughput is one push and one pop per cycle, sustained.
- `full`, `afull`, `empty` and `count` are registered-derived, so they change only at `clk` edges, never combinationally from `wr_en` or `rd_en`.
- No combinational path runs from `wr_en`/`rd_en` to any output. `rd_data` depends only on `rd_ptr` and RAM contents.

## Test plan

- Reset then fill: after reset, push 0x01..0x10 (D=16) on consecutive cycles.
  - `count` steps 1..16; `afull` rises after the 12th push and `full` after the 16th.
  - A 17th push leaves `count=16`, sets `ovf=1`, and leaves `mem[0]=0x01` intact.
- Drain and underflow: from full, pop 16 times.
  - `rd_data` reads 0x01..0x10 in order and `empty=1` after the 16th pop.
  - A 17th pop sets `udf=1` and leaves `count=0`.
- Wrap-around: repeat push-one/pop-one 40 times with data 0x00..0x27.
  - Each popped value equals the pushed value and `count` stays at most 1.
  - Pointers wrap twice with no data error.
- Simultaneous push and pop:
  - At count=5 with both asserted, count stays 5 and order is preserved.
  - At count=0 with both asserted, count=1, `udf=1`, and `rd_data` equals the pushed word next cycle.
  - At count=16 with both asserted, count=15 and `ovf=1`.
- Error clear: with `ovf=udf=1`, pulse `clr_err` for one cycle and both flags clear. Asserting `clr_err` together with a push while full keeps `ovf=1`.
- Async reset mid-stream: with count=7, drive `rst_n` low between clock edges.
  - `count=0`, `empty=1`, `ovf=udf=0` before the next edge.
  - After release, a push of 0xA5 makes `rd_data=0xA5`.

Source files
------------

// File: rtl/dram_fifo.sv
// Synchronous first-word-fall-through FIFO on distributed RAM with an asynchronous read port.
// Tracks occupancy, threshold flags and sticky overflow/underflow errors.
module dram_fifo #(
  parameter int WIDTH       = 8,
  parameter int ADDR_BITS   = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 empty,
  output logic                 full,
  output logic                 afull,
  output logic [ADDR_BITS:0]   count,
  output logic                 ovf,
  output logic                 udf,
  input  logic                 clr_err
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_C = DEPTH[ADDR_BITS:0];
  localparam logic [ADDR_BITS:0] AFULL_C = AFULL_LEVEL[ADDR_BITS:0];

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 push;
  logic                 pop;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign afull = (count >= AFULL_C);

  // rst_n gating keeps the RAM untouched by requests seen while reset is held.
  assign push = wr_en && !full && rst_n;
  assign pop  = rd_en && !empty;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      // A new error event in the same cycle takes precedence over the clear.
      if (wr_en && full) begin
        ovf <= 1'b1;
      end else if (clr_err) begin
        ovf <= 1'b0;
      end
      if (rd_en && empty) begin
        udf <= 1'b1;
      end else if (clr_err) begin
        udf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dram_fifo.sv
// Directed self-checking bench for dram_fifo at the default 8-bit x 16 geometry.
module tb_dram_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       afull;
  logic [4:0] count;
  logic       ovf;
  logic       udf;
  logic       clr_err;

  int checks = 0;
  int errors = 0;

  dram_fifo #(.WIDTH(8), .ADDR_BITS(4), .AFULL_LEVEL(12)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .afull   (afull),
    .count   (count),
    .ovf     (ovf),
    .udf     (udf),
    .clr_err (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    tick();
    tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", afull, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    rst_n = 1'b1;

    // fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      tick();
      chk("fill_count", count, 32'(i));
      chk("fill_afull", afull, (i >= 12) ? 1 : 0);
      chk("fill_full", full, (i == 16) ? 1 : 0);
      chk("fill_empty", empty, 0);
    end
    wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    chk("ovf_count", count, 16);
    chk("ovf_set", ovf, 1);
    chk("ovf_head", rd_data, 8'h01);

    // drain
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", rd_data, 32'(i));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("udf_set", udf, 1);
    chk("udf_count", count, 0);
    chk("udf_keep_ovf", ovf, 1);

    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_ovf", ovf, 0);
    chk("clr_udf", udf, 0);

    // wrap-around push-one/pop-one
    for (int i = 0; i < 40; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      tick();
      wr_en = 1'b0;
      chk("wrap_count1", count, 1);
      chk("wrap_data", rd_data, 32'(i));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("wrap_count0", count, 0);
    end

    // simultaneous at count 5
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h50 + i);
      tick();
    end
    chk("sim5_pre", count, 5);
    rd_en   = 1'b1;
    wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("sim5_count", count, 5);
    for (int i = 1; i <= 5; i++) begin
      chk("sim5_order", rd_data, 32'(8'h50 + i));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    chk("sim5_empty", empty, 1);

    // simultaneous at count 0
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 8'h66;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("sim0_count", count, 1);
    chk("sim0_udf", udf, 1);
    chk("sim0_data", rd_data, 8'h66);
    rd_en   = 1'b1;
    clr_err = 1'b1;
    tick();
    rd_en   = 1'b0;
    clr_err = 1'b0;
    chk("sim0_drain", count, 0);
    chk("sim0_clr", udf, 0);

    // simultaneous at count 16
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h80 + i);
      tick();
    end
    chk("sim16_full", full, 1);
    rd_en   = 1'b1;
    wr_data = 8'hFF;
    tick();
    rd_en = 1'b0;
    chk("sim16_count", count, 15);
    chk("sim16_ovf", ovf, 1);
    chk("sim16_head", rd_data, 8'h81);
    wr_data = 8'h90;
    tick();
    chk("refill_full", full, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    wr_en   = 1'b0;
    chk("clr_vs_set_ovf", ovf, 1);
    chk("clr_vs_set_count", count, 16);

    // async reset mid-stream at count 7
    for (int i = 0; i < 9; i++) begin
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    chk("pre_rst_count", count, 7);
    chk("pre_rst_head", rd_data, 8'h8A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_ovf", ovf, 0);
    chk("arst_udf", udf, 0);
    tick();
    rst_n   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    chk("post_rst_count", count, 1);
    chk("post_rst_data", rd_data, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
